// File: rtl/cache_axi_arbiter_if.sv
// Bus bundle between the cache requesters, the arbiter and the AXI bridge request port.
// The arbiter uses the slave view; requesters and bridge together use the master view.
interface cache_axi_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_write;
  logic [3*NREQ-1:0]    req_type;
  logic [32*NREQ-1:0]   req_addr;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      ret_valid;
  logic [NREQ-1:0]      ret_last;
  logic [NREQ-1:0]      wr_done;

  logic                 m_req_valid;
  logic                 m_req_write;
  logic [2:0]           m_req_type;
  logic [31:0]          m_req_addr;
  logic                 m_req_ready;
  logic                 m_ret_valid;
  logic                 m_ret_last;
  logic                 m_wr_done;

  modport slave (
    input  req_valid, req_write, req_type, req_addr,
    output req_ready, ret_valid, ret_last, wr_done,
    output m_req_valid, m_req_write, m_req_type, m_req_addr,
    input  m_req_ready, m_ret_valid, m_ret_last, m_wr_done
  );

  modport master (
    output req_valid, req_write, req_type, req_addr,
    input  req_ready, ret_valid, ret_last, wr_done,
    input  m_req_valid, m_req_write, m_req_type, m_req_addr,
    output m_req_ready, m_ret_valid, m_ret_last, m_wr_done
  );
endinterface

// File: rtl/cache_axi_arbiter.sv
// Round-robin arbiter sharing the bridge request port among NREQ cache requesters,
// holding each grant until its transaction completes or the watchdog aborts it.
module cache_axi_arbiter #(
  parameter  int NREQ    = 3,
  parameter  int TIMEOUT = 1024,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  cache_axi_arbiter_if.slave    bus,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    WAIT_WR = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic             write_q, write_d;
  logic [2:0]       type_q, type_d;
  logic [31:0]      addr_q, addr_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic             timeout_err_q, timeout_err_d;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [NREQ-1:0]  grant_oh;
  logic             wdog_expired;

  // Scan starts one past the previous owner so every slot gets its turn.
  always_comb begin
    int unsigned cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant_q) + k) % NREQ;
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = IDW'(cand);
      end
    end
  end

  assign grant_oh     = NREQ'(1) << grant_q;
  assign wdog_expired = (TIMEOUT != 0) && (wdog_q == WDW'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    write_d       = write_q;
    type_d        = type_q;
    addr_d        = addr_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
    bus.req_ready   = '0;
    bus.ret_valid   = '0;
    bus.ret_last    = '0;
    bus.wr_done     = '0;
    bus.m_req_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          write_d = bus.req_write[win_idx];
          type_d  = bus.req_type[3*win_idx +: 3];
          addr_d  = bus.req_addr[32*win_idx +: 32];
          state_d = REQ;
        end
      end
      REQ: begin
        bus.m_req_valid = 1'b1;
        if (bus.m_req_ready) begin
          bus.req_ready = grant_oh;
          wdog_d        = '0;
          state_d       = write_q ? WAIT_WR : WAIT_RD;
        end
      end
      WAIT_RD: begin
        bus.ret_valid = bus.m_ret_valid ? grant_oh : '0;
        bus.ret_last  = (bus.m_ret_valid && bus.m_ret_last) ? grant_oh : '0;
        // Completion is checked first so it beats a coincident timeout.
        if (bus.m_ret_valid && bus.m_ret_last) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end else if (wdog_expired) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
          last_grant_d  = grant_q;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      WAIT_WR: begin
        bus.wr_done = bus.m_wr_done ? grant_oh : '0;
        if (bus.m_wr_done) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end else if (wdog_expired) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
          last_grant_d  = grant_q;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      last_grant_q  <= IDW'(NREQ - 1);
      grant_q       <= '0;
      write_q       <= 1'b0;
      type_q        <= '0;
      addr_q        <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      write_q       <= write_d;
      type_q        <= type_d;
      addr_q        <= addr_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.m_req_write = write_q;
  assign bus.m_req_type  = type_q;
  assign bus.m_req_addr  = addr_q;
  assign grant_id        = grant_q;
  assign busy            = (state_q != IDLE);
  assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: inputs change on the falling edge and
// outputs are checked 1 ns later, well away from the rising edge.
module tb_cache_axi_arbiter;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 8;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] addrs [3];
  int          order [4];

  cache_axi_arbiter_if #(.NREQ(NREQ)) bus ();

  cache_axi_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .bus         (bus.slave),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: wait for the falling edge, drive, let combinational paths settle.
  task automatic applyStimulus(input logic [2:0] rv, input logic [2:0] rw,
                               input logic mrr, input logic mrv, input logic mrl,
                               input logic mwd);
    @(negedge aclk);
    bus.req_valid   = rv;
    bus.req_write   = rw;
    bus.m_req_ready = mrr;
    bus.m_ret_valid = mrv;
    bus.m_ret_last  = mrl;
    bus.m_wr_done   = mwd;
    #1;
  endtask

  initial begin
    addrs[0] = 32'h1000_0000;
    addrs[1] = 32'h2000_0080;
    addrs[2] = 32'h1c00_0040;
    order[0] = 0;
    order[1] = 1;
    order[2] = 2;
    order[3] = 0;
    bus.req_type = {3'b100, 3'b100, 3'b010};
    bus.req_addr = {addrs[2], addrs[1], addrs[0]};

    // Reset state
    aresetn = 1'b0;
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grant", 32'(grant_id), 32'd0);
    checkOutput("rst_mvalid", 32'(bus.m_req_valid), 32'd0);
    checkOutput("rst_addr", bus.m_req_addr, 32'd0);
    checkOutput("rst_terr", 32'(timeout_err), 32'd0);
    aresetn = 1'b1;

    // All three requesting continuously: grant order 0,1,2,0
    for (int t = 0; t < 4; t++) begin
      applyStimulus(3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_idle_busy", 32'(busy), 32'd0);
      checkOutput("t1_idle_mvalid", 32'(bus.m_req_valid), 32'd0);
      applyStimulus(3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_mvalid", 32'(bus.m_req_valid), 32'd1);
      checkOutput("t1_grant", 32'(grant_id), 32'(order[t]));
      checkOutput("t1_req_ready", 32'(bus.req_ready), 32'd1 << order[t]);
      checkOutput("t1_addr", bus.m_req_addr, addrs[order[t]]);
      applyStimulus(3'b111, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("t1_ret_valid", 32'(bus.ret_valid), 32'd1 << order[t]);
      checkOutput("t1_ret_last", 32'(bus.ret_last), 32'd1 << order[t]);
    end
    checkOutput("t1_slot0_type", 32'(bus.m_req_type), 32'h2);

    // Slot 1 read line, accepted on the third REQ cycle, four beats
    applyStimulus(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_idle_busy", 32'(busy), 32'd0);
    applyStimulus(3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_grant", 32'(grant_id), 32'd1);
    checkOutput("t2_type", 32'(bus.m_req_type), 32'h4);
    checkOutput("t2_no_ready", 32'(bus.req_ready), 32'd0);
    applyStimulus(3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_grant_held", 32'(grant_id), 32'd1);
    applyStimulus(3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_req_ready", 32'(bus.req_ready), 32'h2);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, (b == 3), 1'b0);
      checkOutput("t2_ret_valid", 32'(bus.ret_valid), 32'h2);
      checkOutput("t2_ret_last", 32'(bus.ret_last), (b == 3) ? 32'h2 : 32'h0);
    end
    // Beats while idle must not be routed
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_done_busy", 32'(busy), 32'd0);
    checkOutput("t6_idle_ret_valid", 32'(bus.ret_valid), 32'd0);
    checkOutput("t6_idle_ret_last", 32'(bus.ret_last), 32'd0);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_idle_stays", 32'(busy), 32'd0);

    // Slot 2 write, done after five WAIT_WR cycles
    applyStimulus(3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_grant", 32'(grant_id), 32'd2);
    checkOutput("t3_write", 32'(bus.m_req_write), 32'd1);
    checkOutput("t3_addr", bus.m_req_addr, 32'h1c00_0040);
    checkOutput("t3_req_ready", 32'(bus.req_ready), 32'h4);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(3'b000, 3'b000, 1'b0, (c == 2), (c == 2), 1'b0);
      checkOutput("t3_wr_done_low", 32'(bus.wr_done), 32'd0);
      checkOutput("t3_no_ret", 32'(bus.ret_valid), 32'd0);
      checkOutput("t3_busy", 32'(busy), 32'd1);
    end
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_wr_done", 32'(bus.wr_done), 32'h4);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_wr_done_pulse", 32'(bus.wr_done), 32'd0);
    checkOutput("t3_idle", 32'(busy), 32'd0);

    // Slot 0 read that never returns: watchdog aborts after 8 WAIT_RD cycles
    applyStimulus(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_grant", 32'(grant_id), 32'd0);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, (c == 1));
      checkOutput("t4_busy", 32'(busy), 32'd1);
      checkOutput("t4_terr_low", 32'(timeout_err), 32'd0);
      checkOutput("t6_rd_no_wr_done", 32'(bus.wr_done), 32'd0);
    end
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_terr", 32'(timeout_err), 32'd1);
    checkOutput("t4_idle", 32'(busy), 32'd0);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_terr_sticky", 32'(timeout_err), 32'd1);

    // Reset during the second read beat of slot 1
    applyStimulus(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_grant", 32'(grant_id), 32'd1);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_beat1", 32'(bus.ret_valid), 32'h2);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    aresetn = 1'b0;
    checkOutput("t5_beat2", 32'(bus.ret_valid), 32'h2);
    applyStimulus(3'b111, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_ret_dropped", 32'(bus.ret_valid), 32'd0);
    checkOutput("t5_grant_rst", 32'(grant_id), 32'd0);
    checkOutput("t5_terr_clr", 32'(timeout_err), 32'd0);
    checkOutput("t5_addr_rst", bus.m_req_addr, 32'd0);
    checkOutput("t5_mvalid", 32'(bus.m_req_valid), 32'd0);
    aresetn = 1'b1;
    applyStimulus(3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_regrant", 32'(grant_id), 32'd0);
    checkOutput("t5_regrant_valid", 32'(bus.m_req_valid), 32'd1);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_ret_last", 32'(bus.ret_last), 32'h1);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_final_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
